// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: word push handshake between a producer and the uart_word_tx serializer.
//
// Parameters:
//   DATA_WIDTH - width of a pushed word.
// Signals:
//   word_valid_i - producer offers word_data_i this cycle.
//   word_data_i  - word to send; byte 0 ([7:0]) goes out first.
//   word_ready_o - serializer FIFO can take a word.
// The signal names match the serializer's port list, so the _i/_o affixes are seen from
// the serializer's side.
// Modports:
//   master - producer side (drives valid/data).
//   slave  - serializer side (drives ready).
interface uart_word_tx_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  word_valid_i;
  logic [DATA_WIDTH-1:0] word_data_i;
  logic                  word_ready_o;

  modport master (
    output word_valid_i,
    output word_data_i,
    input  word_ready_o
  );

  modport slave (
    input  word_valid_i,
    input  word_data_i,
    output word_ready_o
  );
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: buffers DATA_WIDTH-bit words in a FIFO and streams each one out as
// DATA_WIDTH/8 little-endian 8N1/8N2 UART frames (byte 0 first, LSB first).
//
// Parameters:
//   DATA_WIDTH - word width, a multiple of 8.
//   FIFO_DEPTH - word FIFO entries, a power of 2 and at least 2.
//   CPB_W      - width of the clocks-per-bit input.
// Ports:
//   clk_i          - clock.
//   rst_i          - synchronous active-high reset; aborts any frame and empties the FIFO.
//   clks_per_bit_i - cycles per UART bit (values below 2 act as 2), latched per word.
//   stop_bits_i    - 0: one stop bit, 1: two stop bits; latched per word.
//   parity_odd_i   - (parity build only) invert the even-parity bit; latched per word.
//   word_if        - push handshake (valid/data in, ready out).
//   tx_o           - registered serial line, idle high.
//   busy_o         - serializer active or FIFO non-empty.
//   fifo_level_o   - words waiting in the FIFO (not counting the one being sent).
//   byte_done_o    - one-cycle pulse after each frame's last stop bit.
//   word_done_o    - one-cycle pulse together with the last byte's byte_done_o.
// Build option:
//   UART_WORD_TX_PARITY_EN - adds a parity bit after the data bits and the parity_odd_i port.
module uart_word_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CPB_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [CPB_W-1:0]            clks_per_bit_i,
  input  logic                        stop_bits_i,
`ifdef UART_WORD_TX_PARITY_EN
  input  logic                        parity_odd_i,
`endif
  uart_word_tx_if.slave               word_if,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        byte_done_o,
  output logic                        word_done_o
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned LW     = PW + 1;
  localparam int unsigned BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_WORD_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head;

  // Ready comes from the registered level only, so a pop in the same cycle cannot make
  // room for a push into a full FIFO.
  assign word_if.word_ready_o = (level_q < LW'(FIFO_DEPTH));
  assign push                 = word_if.word_valid_i && word_if.word_ready_o;
  assign head                 = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= word_if.word_data_i;
  end

  // ---------------------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CPB_W-1:0]      cpb_q, cpb_d;
  logic [CPB_W-1:0]      timer_q, timer_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_second_q, stop_second_d;
  logic [BIW-1:0]        byte_idx_q, byte_idx_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  byte_done_q, byte_done_d;
  logic                  word_done_q, word_done_d;
`ifdef UART_WORD_TX_PARITY_EN
  logic                  odd_q, odd_d;
  logic                  par_q, par_d;
`endif

  logic [CPB_W-1:0]      cpb_in;
  logic [CPB_W-1:0]      bit_reload;
  logic                  bit_end;
  logic                  load_word;

  assign cpb_in     = (clks_per_bit_i < CPB_W'(2)) ? CPB_W'(2) : clks_per_bit_i;
  assign bit_reload = cpb_q - 1'b1;
  assign bit_end    = (timer_q == '0);

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cpb_d         = cpb_q;
    timer_d       = timer_q;
    stop2_d       = stop2_q;
    stop_second_d = stop_second_q;
    byte_idx_d    = byte_idx_q;
    bit_cnt_d     = bit_cnt_q;
    tx_d          = tx_q;
    byte_done_d   = 1'b0;
    word_done_d   = 1'b0;
    load_word     = 1'b0;
    pop           = 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
    odd_d         = odd_q;
    par_d         = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (level_q != '0) load_word = 1'b1;
      end

      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          timer_d   = bit_reload;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
`ifdef UART_WORD_TX_PARITY_EN
          par_d     = (^shift_q[7:0]) ^ odd_q;
`endif
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      StData: begin
        if (bit_end) begin
          // The whole word shifts right, so after 8 bits the next byte sits in [7:0].
          shift_d = shift_q >> 1;
          timer_d = bit_reload;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
            state_d = StParity;
            tx_d    = par_q;
`else
            state_d       = StStop;
            stop_second_d = 1'b0;
            tx_d          = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

`ifdef UART_WORD_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d       = StStop;
          stop_second_d = 1'b0;
          timer_d       = bit_reload;
          tx_d          = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`endif

      StStop: begin
        if (bit_end) begin
          if (stop2_q && !stop_second_q) begin
            stop_second_d = 1'b1;
            timer_d       = bit_reload;
          end else begin
            byte_done_d = 1'b1;
            if (byte_idx_q != BIW'(NBYTES - 1)) begin
              byte_idx_d = byte_idx_q + 1'b1;
              state_d    = StStart;
              timer_d    = bit_reload;
              tx_d       = 1'b0;
            end else begin
              word_done_d = 1'b1;
              if (level_q != '0) begin
                load_word = 1'b1;
              end else begin
                state_d = StIdle;
                tx_d    = 1'b1;
              end
            end
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Start a new word: configuration is sampled here and held until the word completes.
    if (load_word) begin
      pop        = 1'b1;
      shift_d    = head;
      cpb_d      = cpb_in;
      stop2_d    = stop_bits_i;
      byte_idx_d = '0;
      timer_d    = cpb_in - 1'b1;
      state_d    = StStart;
      tx_d       = 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
      odd_d      = parity_odd_i;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      shift_q       <= '0;
      cpb_q         <= CPB_W'(2);
      timer_q       <= '0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
      byte_idx_q    <= '0;
      bit_cnt_q     <= '0;
      tx_q          <= 1'b1;
      byte_done_q   <= 1'b0;
      word_done_q   <= 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
      odd_q         <= 1'b0;
      par_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cpb_q         <= cpb_d;
      timer_q       <= timer_d;
      stop2_q       <= stop2_d;
      stop_second_q <= stop_second_d;
      byte_idx_q    <= byte_idx_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_q          <= tx_d;
      byte_done_q   <= byte_done_d;
      word_done_q   <= word_done_d;
`ifdef UART_WORD_TX_PARITY_EN
      odd_q         <= odd_d;
      par_q         <= par_d;
`endif
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != StIdle) || (level_q != '0);
  assign fifo_level_o = level_q;
  assign byte_done_o  = byte_done_q;
  assign word_done_o  = word_done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;
  localparam int unsigned DW   = 32;
  localparam int unsigned DEP  = 4;
  localparam int unsigned CPBW = 16;
  localparam int          NB   = 4;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int          PAR  = 1;
`else
  localparam int          PAR  = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CPBW-1:0] cpb_in = 16'd4;
  logic            stop_in = 1'b0;
  logic            odd_in = 1'b0;
  logic            tx, busy, bdone, wdone;
  logic [2:0]      level;

  uart_word_tx_if #(.DATA_WIDTH(DW)) wif ();

  uart_word_tx #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEP),
    .CPB_W     (CPBW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clks_per_bit_i(cpb_in),
    .stop_bits_i   (stop_in),
`ifdef UART_WORD_TX_PARITY_EN
    .parity_odd_i  (odd_in),
`endif
    .word_if       (wif.slave),
    .tx_o          (tx),
    .busy_o        (busy),
    .fifo_level_o  (level),
    .byte_done_o   (bdone),
    .word_done_o   (wdone)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: one UART frame.
  typedef struct {
    logic [7:0] b;
    bit         first;
    bit         last;
    int         acc;     // edge index at which the word was accepted
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   mon_active = 1'b0;

  // Input values as they were at the most recent rising edge.
  int   samp_cpb;
  bit   samp_stop, samp_odd;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    samp_cpb  <= int'(cpb_in);
    samp_stop <= stop_in;
    samp_odd  <= odd_in;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Expected line level for bit slot n of a frame carrying byte b.
  function automatic bit frame_bit(input logic [7:0] b, input int n, input bit odd);
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    if (PAR == 1 && n == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  // Monitor: walks the expected frames cycle by cycle and compares tx and the done pulses.
  initial begin : monitor
    ent_t cur;
    int   idx, total, end_cyc, cpbv;
    bit   stopv, oddv, end_last, exp_tx, exp_b, exp_w;
    end_cyc  = -1;
    end_last = 1'b0;
    cpbv     = 2;
    stopv    = 1'b0;
    oddv     = 1'b0;
    idx      = 0;
    total    = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mon_active = 1'b0;
        end_cyc    = -1;
        continue;
      end
      exp_b = (end_cyc == cyc);
      exp_w = exp_b && end_last;
      if (!mon_active && exp_q.size() > 0 && (!exp_q[0].first || exp_q[0].acc + 1 <= cyc)) begin
        cur = exp_q.pop_front();
        if (cur.first) begin
          cpbv  = (samp_cpb < 2) ? 2 : samp_cpb;
          stopv = samp_stop;
          oddv  = samp_odd;
        end
        total      = (10 + PAR + int'(stopv)) * cpbv;
        idx        = 0;
        mon_active = 1'b1;
      end
      exp_tx = mon_active ? frame_bit(cur.b, idx / cpbv, oddv) : 1'b1;
      chk("tx_line", int'(tx), int'(exp_tx));
      chk("byte_done", int'(bdone), int'(exp_b));
      chk("word_done", int'(wdone), int'(exp_w));
      if (mon_active) begin
        idx++;
        if (idx == total) begin
          mon_active = 1'b0;
          end_cyc    = cyc + 1;
          end_last   = cur.last;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [31:0] w, input int a);
    ent_t e;
    for (int i = 0; i < NB; i++) begin
      e.b     = w[8*i +: 8];
      e.first = (i == 0);
      e.last  = (i == NB - 1);
      e.acc   = a;
      exp_q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns the edge index at which the word was taken.
  task automatic push_word(input logic [31:0] w, output int a);
    bit ok;
    ok = 1'b0;
    a  = -1;
    wif.word_valid_i = 1'b1;
    wif.word_data_i  = w;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = wif.word_ready_o;
      a  = cyc + 1;
      @(posedge clk);
      #1;
      if (ok) enqueue(w, a);
    end
    wif.word_valid_i = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  // which: 0 = tx low, 1 = byte_done, 2 = word_done. Returns the cycle seen, or -1.
  task automatic wait_sig(input int which, input int lim, output int c, output int nb);
    bit hit;
    hit = 1'b0;
    c   = -1;
    nb  = 0;
    for (int t = 0; t < lim && !hit; t++) begin
      @(negedge clk);
      if (bdone) nb++;
      hit = (which == 0) ? !tx : (which == 1) ? bdone : wdone;
      if (hit) c = cyc;
    end
    if (!hit) chk("wait_timeout", which, -1);
  endtask

  task automatic drain(input int lim);
    bit done;
    done = 1'b0;
    for (int t = 0; t < lim && !done; t++) begin
      @(negedge clk);
      done = !busy && exp_q.size() == 0 && !mon_active;
    end
    chk("drain_done", int'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a, a2, c0, c1, c2, nb, n;
    logic [31:0] w;
    wif.word_valid_i = 1'b0;
    wif.word_data_i  = '0;

    // Reset state
    tick(3);
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_ready", int'(wif.word_ready_o), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_bdone", int'(bdone), 0);
    chk("rst_wdone", int'(wdone), 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Basic word: cpb=4, one stop bit
    cpb_in  = 16'd4;
    stop_in = 1'b0;
    push_word(32'h0020_0113, a);
    wait_sig(0, 20, c0, nb);
    chk("basic_fall_latency", c0 - a, 1);
    wait_sig(2, 400, c1, nb);
    chk("basic_word_cycles", c1 - c0, 160);
    chk("basic_byte_pulses", nb, 4);
    drain(50);

    // Back-pressure: cpb=8, valid held with distinct words
    cpb_in = 16'd8;
    n = 0;
    wif.word_valid_i = 1'b1;
    for (int t = 0; t < 20; t++) begin
      w = 32'h1000_0000 + 32'(n) * 32'h0101_0101;
      wif.word_data_i = w;
      @(negedge clk);
      if (!wif.word_ready_o) break;
      a = cyc + 1;
      @(posedge clk);
      #1;
      enqueue(w, a);
      n++;
    end
    chk("bp_accepted", n, 5);
    chk("bp_level_full", int'(level), 4);
    chk("bp_ready_low", int'(wif.word_ready_o), 0);
    @(posedge clk);
    #1;
    wif.word_valid_i = 1'b0;
    drain(5000);

    // Clamp and two stop bits
    cpb_in  = 16'd0;
    stop_in = 1'b1;
    push_word(32'hA5A5_A5A5, a);
    wait_sig(0, 20, c0, nb);
    wait_sig(2, 200, c1, nb);
    chk("clamp_word_cycles", c1 - c0, 88);
    drain(50);

    // Config change mid-word takes effect on the next word
    cpb_in  = 16'd4;
    stop_in = 1'b0;
    push_word(32'h1122_3344, a);
    push_word(32'h5566_7788, a2);
    wait_sig(1, 100, c0, nb);
    tick(5);
    cpb_in = 16'd6;
    wait_sig(2, 400, c1, nb);
    wait_sig(2, 600, c2, nb);
    chk("cfg_next_word_cycles", c2 - c1, 240);
    drain(50);

    // Reset in DATA of byte 2 with two words queued
    cpb_in = 16'd4;
    push_word(32'hDEAD_BEEF, a);
    push_word(32'h0BAD_F00D, a);
    push_word(32'h1234_5678, a);
    chk("rst_pre_level", int'(level), 2);
    wait_sig(1, 200, c0, nb);
    wait_sig(1, 200, c0, nb);
    @(posedge clk);
    #1;
    tick(15);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_level", int'(level), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_bdone", int'(bdone), 0);
    chk("midrst_wdone", int'(wdone), 0);
    chk("midrst_ready", int'(wif.word_ready_o), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    tick(60);
    chk("midrst_idle_busy", int'(busy), 0);

`ifdef UART_WORD_TX_PARITY_EN
    // Parity: even then odd
    cpb_in  = 16'd4;
    stop_in = 1'b0;
    odd_in  = 1'b0;
    push_word(32'h0000_0007, a);
    wait_sig(0, 20, c0, nb);
    wait_sig(2, 400, c1, nb);
    chk("par_word_cycles", c1 - c0, 176);
    drain(50);
    odd_in = 1'b1;
    push_word(32'h0000_0007, a);
    drain(400);
`endif

    // Randomized words, settings and gaps
    for (int i = 0; i < 10; i++) begin
      cpb_in  = 16'($urandom_range(0, 5));
      stop_in = 1'($urandom_range(0, 1));
      odd_in  = 1'($urandom_range(0, 1));
      tick($urandom_range(0, 30));
      push_word($urandom, a);
    end
    drain(8000);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Synthesizable, parametrised UART serializer that streams DATA_WIDTH-bit words as little-endian 8-bit UART frames.
- Words are buffered in an internal FIFO.
- Used by the SoC-level loader harness and by on-chip debug logic to feed instruction images into the uart_rx_inst path of opentitan_soc_top.
- Adds runtime bit period, selectable stop bits and back-pressure.

Parameters:
DATA_WIDTH, 32, word width; must be a multiple of 8 (NBYTES = DATA_WIDTH/8).
FIFO_DEPTH, 4, word FIFO entries; power of 2, >= 2.
CPB_W, 16, width of the clocks-per-bit input.

Ports:
clk_i  in  1  single clock for all logic.
rst_i  in  1  synchronous, active-high reset.
clks_per_bit_i  in  CPB_W  clock cycles per UART bit; values < 2 are treated as 2.
stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits.
word_valid_i  in  1  word push request.
word_data_i  in  DATA_WIDTH  word to send; byte 0 = [7:0] is sent first.
word_ready_o  out  1  FIFO can accept a word.
tx_o  out  1  serial line, registered, idle high.
busy_o  out  1  serializer not in IDLE, or FIFO not empty.
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO, excluding the word in the serializer.
byte_done_o  out  1  one-cycle pulse at the end of each frame's last stop bit.
word_done_o  out  1  one-cycle pulse with the byte_done_o of byte NBYTES-1.

Behaviour:
- Reset (rst_i high at an edge): tx_o=1, word_ready_o=1, busy_o=0, fifo_level_o=0, byte_done_o=0, word_done_o=0.
  - FIFO is emptied and the FSM goes to IDLE.
  - Mid-frame reset aborts the frame; tx_o is high after that edge. No done pulses are generated.
- Push:
  - Accepted at an edge where word_valid_i && word_ready_o.
  - word_ready_o = (fifo_level_o < FIFO_DEPTH), driven combinationally from registered level.
  - A push while full is ignored. A same-cycle pop does not free the slot for that push.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: tx_o=1. If the FIFO is non-empty at an edge:
    - pop the word into the shift register;
    - latch cpb = max(clks_per_bit_i, 2) and stop_bits_i;
    - byte index = 0, go to START (tx_o=0 from that edge).
    - Push at edge E into an empty FIFO gives tx_o low from edge E+1.
  - START: hold 0 for cpb cycles, then go to DATA.
  - DATA: 8 bits LSB-first, cpb cycles each; a 3-bit counter counts bits.
  - STOP: tx_o=1 for cpb cycles (2*cpb if two stop bits).
    - On the final cycle, pulse byte_done_o.
    - If byte index < NBYTES-1: increment it and go to START with no idle gap.
    - Otherwise pulse word_done_o, then:
      - if the FIFO is non-empty, pop immediately and go to START (no gap);
      - else go to IDLE.
- Bit timer:
  - CPB_W-bit down-counter, loaded with cpb-1 on each bit entry.
  - Bit advances when the counter reaches 0.
- Latched cpb and stop_bits hold for the whole word; changes to the inputs mid-word take effect at the next word.
- Word duration (no parity) = NBYTES*(10 + stop_bits)*cpb cycles.

Optional Feature:
- Macro: UART_WORD_TX_PARITY_EN.
- Defined:
  - a PARITY state follows DATA: one bit, cpb cycles, even parity (XOR of the 8 data bits);
  - frame = 11 + stop_bits bits;
  - extra input parity_odd_i (1 bit), latched per word; when 1, the parity bit is inverted.
- Undefined:
  - no PARITY state and no parity_odd_i port;
  - frame = 10 + stop_bits bits.

Test Plan:
- Basic word: cpb=4, stop=0, push 0x00200113.
  - tx_o low one edge after the push.
  - Bytes 0x13, 0x01, 0x20, 0x00 sent LSB-first, each framed 0..1.
  - byte_done_o ×4; word_done_o exactly 160 cycles after tx_o first falls.
- Back-pressure: cpb=8, word_valid_i held high with distinct words.
  - Exactly 5 words accepted (1 popped + 4 buffered) before word_ready_o=0 and fifo_level_o=4.
  - Words are emitted back-to-back with no idle cycles between frames.
- Clamp and stop bits: clks_per_bit_i=0 and stop_bits_i=1, push 0xA5A5A5A5.
  - Each bit lasts 2 cycles; stop high lasts 4 cycles; word takes 4*11*2 = 88 cycles.
- Mid-word config change: start a word at cpb=4, switch to cpb=6 during byte 1.
  - The current word stays at 4-cycle bits; the next word uses 6.
- Reset mid-frame: assert rst_i during DATA of byte 2 with 2 words queued.
  - Next edge: tx_o=1, fifo_level_o=0, busy_o=0; no done pulses.
  - Line stays idle until a new push.
- UART_WORD_TX_PARITY_EN: push 0x00000007, cpb=4, parity_odd_i=0.
  - Byte 0 parity bit = 1, bytes 1–3 parity bit = 0; word takes 4*11*4 = 176 cycles.
  - With parity_odd_i=1 the parity bits are inverted.
